// File: rtl/simple_axi_host_arbiter.sv
// -----------------------------------------------------------------------------
// simple_axi_host_arbiter
//   Shares one simple_axi_master host bus among N_REQ requesters using
//   round-robin arbitration. The granted command is registered, the master is
//   driven through an issue / wait / clear handshake, and a one-cycle response
//   pulse is routed back to the requester that won.
//
// Optional feature (compile-time macro SIMPLE_AXI_ARB_LOCK_EN):
//   Adds i_req_lock. A requester accepted with its lock bit set keeps the
//   round-robin pointer on itself, so it wins the next arbitration if it is
//   still requesting (read-modify-write sequences).
//
// Ports
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_req_valid  [N_REQ]          request pending per requester
//   i_req_rw     [2*N_REQ]        op per requester: 00 none, 01 rd, 10 wr, 11 rsvd
//   i_req_size   [3*N_REQ]        AXI size per requester
//   i_req_addr   [32*N_REQ]       byte address per requester
//   i_req_wdata  [DW*N_REQ]       write data per requester
//   i_req_lock   [N_REQ]          (lock build only) hold grant on this requester
//   o_req_ready  [N_REQ]          one-hot, one-cycle accept pulse
//   o_rsp_valid  [N_REQ]          one-hot, one-cycle completion pulse
//   o_rsp_rdata/error/invalid     response payload, held until the next response
//   o_m_rw/size/addr/wdata/clear  command and clear to the master
//   i_m_rdata/wait/done/error/invalid  status from the master
// -----------------------------------------------------------------------------
module simple_axi_host_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [2*N_REQ-1:0]    i_req_rw,
  input  logic [3*N_REQ-1:0]    i_req_size,
  input  logic [32*N_REQ-1:0]   i_req_addr,
  input  logic [DW*N_REQ-1:0]   i_req_wdata,
`ifdef SIMPLE_AXI_ARB_LOCK_EN
  input  logic [N_REQ-1:0]      i_req_lock,
`endif
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_rsp_error,
  output logic                  o_rsp_invalid,
  output logic [2:0]            o_m_size,
  output logic [31:0]           o_m_addr,
  output logic [DW-1:0]         o_m_wdata,
  output logic [1:0]            o_m_rw,
  output logic                  o_m_clear,
  input  logic [DW-1:0]         i_m_rdata,
  input  logic                  i_m_wait,
  input  logic                  i_m_done,
  input  logic                  i_m_error,
  input  logic                  i_m_invalid
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, CLEAR} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;       // round-robin search start
  logic [PW-1:0]   cur;       // requester owning the transaction in flight
  logic [1:0]      cmd_rw;    // accepted op, kept to detect the no-op case

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   next_ptr;
  logic [1:0]      sel_rw;
  logic [2:0]      sel_size;
  logic [31:0]     sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            m_finished;

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

  // Scan from ptr upward (wrapping) and take the first pending requester.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!grant_found && i_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Field mux for the winner.
  always_comb begin
    sel_rw    = '0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_rw    = i_req_rw[2*i +: 2];
        sel_size  = i_req_size[3*i +: 3];
        sel_addr  = i_req_addr[32*i +: 32];
        sel_wdata = i_req_wdata[DW*i +: DW];
      end
    end
  end

  always_comb begin
    next_ptr = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef SIMPLE_AXI_ARB_LOCK_EN
    // A locked accept parks the pointer on the winner.
    if (i_req_lock[grant_idx]) next_ptr = grant_idx;
`endif
  end

  assign m_finished = i_m_done | i_m_error | i_m_invalid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: the command registers are reset too, so the master sees a clean
      // all-zero command after reset rather than stale address/data.
      state         <= IDLE;
      ptr           <= '0;
      cur           <= '0;
      cmd_rw        <= '0;
      o_req_ready   <= '0;
      o_rsp_valid   <= '0;
      o_rsp_rdata   <= '0;
      o_rsp_error   <= 1'b0;
      o_rsp_invalid <= 1'b0;
      o_m_size      <= '0;
      o_m_addr      <= '0;
      o_m_wdata     <= '0;
      o_m_rw        <= '0;
      o_m_clear     <= 1'b0;
    end else begin
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            o_req_ready <= onehot(grant_idx);
            cur         <= grant_idx;
            cmd_rw      <= sel_rw;
            o_m_rw      <= sel_rw;
            o_m_size    <= sel_size;
            o_m_addr    <= sel_addr;
            o_m_wdata   <= sel_wdata;
            ptr         <= next_ptr;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_rw == 2'b00) begin
            // No-op request: answer locally without touching the bus.
            o_rsp_valid   <= onehot(cur);
            o_rsp_error   <= 1'b0;
            o_rsp_invalid <= 1'b1;
            state         <= IDLE;
          end else if (i_m_wait | m_finished) begin
            o_m_rw <= 2'b00;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (m_finished) begin
            o_rsp_valid   <= onehot(cur);
            o_rsp_rdata   <= i_m_rdata;
            o_rsp_error   <= i_m_error;
            o_rsp_invalid <= i_m_invalid;
            o_m_clear     <= 1'b1;
            state         <= CLEAR;
          end
        end
        CLEAR: begin
          // Hold clear until the master has dropped every completion flag.
          if (!m_finished) begin
            o_m_clear <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_axi_host_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_axi_host_arbiter
//   Directed bench for simple_axi_host_arbiter (N_REQ=4, DW=32) with a small
//   behavioural master: wait for m_lat cycles, then done (or error), hold the
//   flags until clear. A reserved op gets an immediate invalid.
// -----------------------------------------------------------------------------
module tb_simple_axi_host_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_rw;
  logic [3*N-1:0]  req_size;
  logic [32*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
`ifdef SIMPLE_AXI_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error, rsp_invalid;
  logic [2:0]      m_size;
  logic [31:0]     m_addr;
  logic [DW-1:0]   m_wdata;
  logic [1:0]      m_rw;
  logic            m_clear;
  logic [DW-1:0]   m_rdata;
  logic            m_wait, m_done, m_error, m_invalid;

  simple_axi_host_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(req_valid), .i_req_rw(req_rw), .i_req_size(req_size),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
`ifdef SIMPLE_AXI_ARB_LOCK_EN
    .i_req_lock(req_lock),
`endif
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_rsp_error(rsp_error), .o_rsp_invalid(rsp_invalid),
    .o_m_size(m_size), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .o_m_rw(m_rw), .o_m_clear(m_clear),
    .i_m_rdata(m_rdata), .i_m_wait(m_wait), .i_m_done(m_done),
    .i_m_error(m_error), .i_m_invalid(m_invalid)
  );

  // ---------------- master model ----------------
  int          m_lat = 1;
  bit          m_err_mode = 1'b0;
  logic [31:0] m_rdata_cfg = 32'h0;
  int          m_st, m_cnt;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      m_st = 0; m_cnt = 0;
      m_wait = 1'b0; m_done = 1'b0; m_error = 1'b0; m_invalid = 1'b0;
      m_rdata = '0;
    end else begin
      case (m_st)
        0: if (m_rw == 2'b11) begin
             m_invalid = 1'b1; m_st = 2;
           end else if (m_rw != 2'b00) begin
             m_wait = 1'b1; m_cnt = m_lat; m_st = 1;
           end
        1: if (m_cnt <= 1) begin
             m_wait = 1'b0; m_done = !m_err_mode; m_error = m_err_mode;
             m_rdata = m_rdata_cfg; m_st = 2;
           end else m_cnt--;
        default: if (m_clear) begin
             m_done = 1'b0; m_error = 1'b0; m_invalid = 1'b0; m_st = 0;
           end
      endcase
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    logic        inv;
    int          cyc;
  } rsp_t;

  int   cyc = 0;
  int   grant_q[$];
  int   gcyc_q[$];
  rsp_t rsp_q[$];
  rsp_t mon_r;
  int   multi_cnt = 0, clear_cnt = 0, rw_cnt = 0;
  logic [1:0]  last_rw;
  logic [31:0] last_addr, last_wdata;
  logic [2:0]  last_size;

  function automatic int oh2idx(input logic [N-1:0] v);
    oh2idx = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) oh2idx = i;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (req_ready != '0) begin
        grant_q.push_back(oh2idx(req_ready));
        gcyc_q.push_back(cyc);
        if ($countones(req_ready) != 1) multi_cnt++;
      end
      if (rsp_valid != '0) begin
        mon_r.idx = oh2idx(rsp_valid); mon_r.rdata = rsp_rdata;
        mon_r.err = rsp_error; mon_r.inv = rsp_invalid; mon_r.cyc = cyc;
        rsp_q.push_back(mon_r);
      end
      if (m_clear) clear_cnt++;
      if (m_rw != 2'b00) begin
        rw_cnt++; last_rw = m_rw; last_addr = m_addr;
        last_wdata = m_wdata; last_size = m_size;
      end
    end
  end

  // ---------------- helpers ----------------
  int n_cmp = 0, n_fail = 0;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int k, input logic [1:0] rw, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    req_rw[2*k +: 2]    = rw;
    req_size[3*k +: 3]  = sz;
    req_addr[32*k +: 32] = a;
    req_wdata[32*k +: 32] = d;
    req_valid[k]        = 1'b1;
  endtask

  task automatic wait_grants(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && grant_q.size() < target; i++) tick();
    if (grant_q.size() >= target) ok = 1'b1;
  endtask

  task automatic wait_rsps(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && rsp_q.size() < target; i++) tick();
    if (rsp_q.size() >= target) ok = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
`ifdef SIMPLE_AXI_ARB_LOCK_EN
    req_lock = '0;
`endif
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b1;
    req_valid = '0; req_rw = '0; req_size = '0; req_addr = '0; req_wdata = '0;
`ifdef SIMPLE_AXI_ARB_LOCK_EN
    req_lock = '0;
`endif
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_error, rsp_invalid, m_rw, m_clear} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {req_ready, rsp_valid, rsp_error, rsp_invalid, m_rw, m_clear});
    end
    n_cmp++;
    if ({m_size, m_addr, m_wdata, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {m_size, m_addr, m_wdata, rsp_rdata});
    end
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int g0, r0, c0;
    bit ok;
    g0 = grant_q.size(); r0 = rsp_q.size(); c0 = clear_cnt;
    m_lat = 3; m_err_mode = 1'b0; m_rdata_cfg = 32'hDEADBEEF;
    set_req(2, 2'b01, 3'd2, 32'h1000, 32'h0);
    wait_grants(g0 + 1, ok);
    req_valid[2] = 1'b0;
    n_cmp++;
    if (!ok || grant_q[g0] !== 2) begin
      n_fail++; $display("FAIL rd_grant: got %0d expected 2 (ok=%0b)", ok ? grant_q[g0] : -1, ok);
    end
    wait_rsps(r0 + 1, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (!ok || rsp_q[r0].idx !== 2 || rsp_q[r0].rdata !== 32'hDEADBEEF ||
        rsp_q[r0].err !== 1'b0 || rsp_q[r0].inv !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got idx %0d data %h err %b inv %b expected 2 deadbeef 0 0",
                         rsp_q[r0].idx, rsp_q[r0].rdata, rsp_q[r0].err, rsp_q[r0].inv);
    end
    n_cmp++;
    if (rsp_q[r0].cyc - gcyc_q[g0] !== 4) begin
      n_fail++; $display("FAIL rd_latency: got %0d expected 4", rsp_q[r0].cyc - gcyc_q[g0]);
    end
    n_cmp++;
    if (last_addr !== 32'h1000 || last_size !== 3'd2 || last_rw !== 2'b01) begin
      n_fail++; $display("FAIL rd_cmd: got addr %h size %0d rw %b expected 1000 2 01",
                         last_addr, last_size, last_rw);
    end
    n_cmp++;
    if (clear_cnt - c0 !== 1) begin
      n_fail++; $display("FAIL rd_clear: got %0d clear cycles expected 1", clear_cnt - c0);
    end
  endtask

  task automatic test_round_robin();
    int g0, r0, mc0;
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    bit ok;
    do_reset();
    g0 = grant_q.size(); r0 = rsp_q.size(); mc0 = multi_cnt;
    m_lat = 1; m_rdata_cfg = 32'h0000_0B0B;
    set_req(0, 2'b01, 3'd2, 32'h100, 32'h0);
    set_req(1, 2'b01, 3'd2, 32'h104, 32'h0);
    set_req(3, 2'b01, 3'd2, 32'h10C, 32'h0);
    wait_grants(g0 + 6, ok);
    req_valid = '0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d grants expected 6", grant_q.size() - g0); end
    wait_rsps(r0 + 6, ok);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (grant_q[g0 + i] !== exp_order[i]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_q[g0 + i], exp_order[i]);
      end
    end
    n_cmp++;
    if (multi_cnt !== mc0 || grant_q.size() !== g0 + 6 || rsp_q.size() !== r0 + 6) begin
      n_fail++; $display("FAIL rr_counts: got multi %0d grants %0d rsps %0d expected 0 6 6",
                         multi_cnt - mc0, grant_q.size() - g0, rsp_q.size() - r0);
    end
    n_cmp++;
    if (gcyc_q[g0 + 1] - gcyc_q[g0] !== 4) begin
      n_fail++; $display("FAIL rr_spacing: got %0d expected 4", gcyc_q[g0 + 1] - gcyc_q[g0]);
    end
  endtask

  task automatic test_write_error();
    int g0, r0;
    bit ok;
    g0 = grant_q.size(); r0 = rsp_q.size();
    m_lat = 2; m_err_mode = 1'b1; m_rdata_cfg = 32'h0;
    set_req(1, 2'b10, 3'd2, 32'h2000, 32'h12345678);
    wait_grants(g0 + 1, ok);
    req_valid[1] = 1'b0;
    wait_rsps(r0 + 1, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (grant_q[g0] !== 1 || last_rw !== 2'b10 || last_wdata !== 32'h12345678 || last_addr !== 32'h2000) begin
      n_fail++; $display("FAIL wr_cmd: got grant %0d rw %b wdata %h addr %h expected 1 10 12345678 2000",
                         grant_q[g0], last_rw, last_wdata, last_addr);
    end
    n_cmp++;
    if (!ok || rsp_q[r0].idx !== 1 || rsp_q[r0].err !== 1'b1 || rsp_q[r0].inv !== 1'b0) begin
      n_fail++; $display("FAIL wr_rsp: got idx %0d err %b inv %b expected 1 1 0",
                         rsp_q[r0].idx, rsp_q[r0].err, rsp_q[r0].inv);
    end
    n_cmp++;
    if (rsp_error !== 1'b1) begin
      n_fail++; $display("FAIL wr_err_hold: got %b expected 1", rsp_error);
    end
    m_err_mode = 1'b0; m_rdata_cfg = 32'hA5A50001;
    set_req(0, 2'b01, 3'd2, 32'h2004, 32'h0);
    wait_grants(g0 + 2, ok);
    req_valid[0] = 1'b0;
    wait_rsps(r0 + 2, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (!ok || rsp_q[r0 + 1].idx !== 0 || rsp_q[r0 + 1].err !== 1'b0 ||
        rsp_q[r0 + 1].rdata !== 32'hA5A50001) begin
      n_fail++; $display("FAIL wr_next: got idx %0d err %b data %h expected 0 0 a5a50001",
                         rsp_q[r0 + 1].idx, rsp_q[r0 + 1].err, rsp_q[r0 + 1].rdata);
    end
  endtask

  task automatic test_null_request();
    int g0, r0, w0;
    bit ok;
    g0 = grant_q.size(); r0 = rsp_q.size(); w0 = rw_cnt;
    set_req(0, 2'b00, 3'd0, 32'h0, 32'h0);
    wait_grants(g0 + 1, ok);
    req_valid[0] = 1'b0;
    wait_rsps(r0 + 1, ok);
    tick(); tick();
    n_cmp++;
    if (!ok || grant_q[g0] !== 0 || rsp_q[r0].idx !== 0 || rsp_q[r0].inv !== 1'b1 || rsp_q[r0].err !== 1'b0) begin
      n_fail++; $display("FAIL null_rsp: got grant %0d idx %0d inv %b err %b expected 0 0 1 0",
                         grant_q[g0], rsp_q[r0].idx, rsp_q[r0].inv, rsp_q[r0].err);
    end
    n_cmp++;
    if (rsp_q[r0].cyc - gcyc_q[g0] !== 1) begin
      n_fail++; $display("FAIL null_latency: got %0d expected 1", rsp_q[r0].cyc - gcyc_q[g0]);
    end
    n_cmp++;
    if (rw_cnt !== w0) begin
      n_fail++; $display("FAIL null_bus: got %0d bus cycles expected 0", rw_cnt - w0);
    end
  endtask

  task automatic test_reserved();
    int g0, r0;
    bit ok;
    g0 = grant_q.size(); r0 = rsp_q.size();
    set_req(2, 2'b11, 3'd2, 32'h2200, 32'h0);
    wait_grants(g0 + 1, ok);
    req_valid[2] = 1'b0;
    wait_rsps(r0 + 1, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (!ok || grant_q[g0] !== 2 || last_rw !== 2'b11 || rsp_q[r0].idx !== 2 ||
        rsp_q[r0].inv !== 1'b1 || rsp_q[r0].err !== 1'b0) begin
      n_fail++; $display("FAIL rsvd: got grant %0d rw %b idx %0d inv %b err %b expected 2 11 2 1 0",
                         grant_q[g0], last_rw, rsp_q[r0].idx, rsp_q[r0].inv, rsp_q[r0].err);
    end
  endtask

  task automatic test_reset_busy();
    int g0, r0;
    bit ok;
    g0 = grant_q.size(); r0 = rsp_q.size();
    m_lat = 10; m_rdata_cfg = 32'h5A5A0003;
    set_req(2, 2'b01, 3'd2, 32'h3000, 32'h0);
    wait_grants(g0 + 1, ok);
    req_valid[2] = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (grant_q[g0] !== 2 || m_addr !== 32'h3000) begin
      n_fail++; $display("FAIL rb_pre: got grant %0d addr %h expected 2 3000", grant_q[g0], m_addr);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_error, rsp_invalid, m_rw, m_clear, m_size, m_addr, m_wdata, rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL rb_outputs: got addr %h rdata %h clear %b expected all 0",
                         m_addr, rsp_rdata, m_clear);
    end
    tick(); tick();
    rstn = 1'b1;
    tick();
    m_lat = 2;
    set_req(1, 2'b01, 3'd2, 32'h1100, 32'h0);
    set_req(3, 2'b01, 3'd2, 32'h3300, 32'h0);
    wait_grants(g0 + 2, ok);
    req_valid[1] = 1'b0;
    wait_grants(g0 + 3, ok);
    req_valid[3] = 1'b0;
    wait_rsps(r0 + 2, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (grant_q[g0 + 1] !== 1 || grant_q[g0 + 2] !== 3) begin
      n_fail++; $display("FAIL rb_ptr: got order %0d,%0d expected 1,3", grant_q[g0 + 1], grant_q[g0 + 2]);
    end
    n_cmp++;
    if (!ok || rsp_q.size() !== r0 + 2 || rsp_q[r0 + 1].idx !== 3 ||
        rsp_q[r0 + 1].rdata !== 32'h5A5A0003 || rsp_q[r0 + 1].err !== 1'b0) begin
      n_fail++; $display("FAIL rb_after: got rsps %0d idx %0d data %h expected 2 3 5a5a0003",
                         rsp_q.size() - r0, rsp_q[r0 + 1].idx, rsp_q[r0 + 1].rdata);
    end
  endtask

  task automatic test_lock();
    int g0, r0;
    bit ok;
    do_reset();
    g0 = grant_q.size(); r0 = rsp_q.size();
    m_lat = 1;
    set_req(0, 2'b01, 3'd2, 32'h4000, 32'h0);
    set_req(1, 2'b01, 3'd2, 32'h4004, 32'h0);
`ifdef SIMPLE_AXI_ARB_LOCK_EN
    req_lock[0] = 1'b1;
    wait_grants(g0 + 1, ok);
    req_lock[0] = 1'b0;
    wait_grants(g0 + 2, ok);
    req_valid[0] = 1'b0;
    wait_grants(g0 + 3, ok);
    req_valid[1] = 1'b0;
    wait_rsps(r0 + 3, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (!ok || grant_q[g0] !== 0 || grant_q[g0 + 1] !== 0 || grant_q[g0 + 2] !== 1) begin
      n_fail++; $display("FAIL lock_order: got %0d,%0d,%0d expected 0,0,1",
                         grant_q[g0], grant_q[g0 + 1], grant_q[g0 + 2]);
    end
`else
    wait_grants(g0 + 1, ok);
    wait_grants(g0 + 2, ok);
    req_valid = '0;
    wait_rsps(r0 + 2, ok);
    tick(); tick(); tick();
    n_cmp++;
    if (!ok || grant_q[g0] !== 0 || grant_q[g0 + 1] !== 1) begin
      n_fail++; $display("FAIL nolock_order: got %0d,%0d expected 0,1", grant_q[g0], grant_q[g0 + 1]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_error();
    test_null_request();
    test_reserved();
    test_reset_busy();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
